// File: rtl/truth_table_checker_if.sv
// ----------------------------------------------------------------------------
// truth_table_checker_if
// Groups the control, stimulus and result signals between a requester
// (master) and the truth-table checker (slave).
//   start      master -> slave  request one full truth-table check
//   abort      master -> slave  cancel a running check
//   func[3:0]  master -> slave  expected output for vector k = {x,y}
//   s          master -> slave  output of the 2-input gate under test
//   x, y       slave  -> master gate inputs (x is MSB of vector index)
//   busy       slave  -> master check in progress
//   done       slave  -> master one-cycle completion pulse
//   pass       slave  -> master last completed check had no mismatches
//   err_count  slave  -> master mismatching vectors so far (0..4)
//   err_mask   slave  -> master bit k set when vector k mismatched
// ----------------------------------------------------------------------------
interface truth_table_checker_if;
    logic       start;
    logic       abort;
    logic [3:0] func;
    logic       s;
    logic       x;
    logic       y;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_count;
    logic [3:0] err_mask;

    modport master (
        output start, abort, func, s,
        input  x, y, busy, done, pass, err_count, err_mask
    );

    modport slave (
        input  start, abort, func, s,
        output x, y, busy, done, pass, err_count, err_mask
    );
endinterface

// File: rtl/truth_table_checker.sv
// ----------------------------------------------------------------------------
// truth_table_checker
// Drives the four input vectors {x,y} = 00,01,10,11 into a 2-input gate,
// holds each for SETTLE cycles, samples the gate output s on the last cycle
// of each vector and compares it with func[{x,y}]. Mismatches are recorded
// in err_mask / err_count; pass and a one-cycle done pulse report the end.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    truth_table_checker_if slave modport (see interface header)
// Parameter:
//   SETTLE hold cycles per vector, 1..15
// ----------------------------------------------------------------------------
module truth_table_checker #(
    parameter int unsigned SETTLE = 2
) (
    input logic                  clk,
    input logic                  rst_n,
    truth_table_checker_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic       x_q, x_d;
    logic       y_q, y_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [2:0] err_count_q, err_count_d;
    logic [3:0] err_mask_q, err_mask_d;

    logic       miss;
    logic [2:0] count_next;
    logic [1:0] idx_next;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        x_d         = x_q;
        y_d         = y_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        err_count_d = err_count_q;
        err_mask_d  = err_mask_q;
        miss        = bus.s != bus.func[idx_q];
        count_next  = err_count_q;
        idx_next    = idx_q + 2'd1;

        unique case (state_q)
            IDLE: begin
                x_d    = 1'b0;
                y_d    = 1'b0;
                busy_d = 1'b0;
                if (bus.start) begin
                    state_d     = DRIVE;
                    idx_d       = '0;
                    cnt_d       = '0;
                    err_count_d = '0;
                    err_mask_d  = '0;
                    pass_d      = 1'b0;
                    busy_d      = 1'b1;
                end
            end

            DRIVE: begin
                if (bus.abort) begin
                    // Partial results are kept; only pass is forced low.
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    pass_d  = 1'b0;
                    x_d     = 1'b0;
                    y_d     = 1'b0;
                end else if (cnt_q == SETTLE_LAST) begin
                    if (miss) begin
                        err_mask_d[idx_q] = 1'b1;
                        if (err_count_q < 3'd4) begin
                            count_next = err_count_q + 3'd1;
                        end
                    end
                    err_count_d = count_next;
                    if (idx_q == 2'd3) begin
                        // pass uses the count including the last vector.
                        state_d = DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        pass_d  = (count_next == 3'd0);
                        x_d     = 1'b0;
                        y_d     = 1'b0;
                    end else begin
                        idx_d = idx_next;
                        cnt_d = '0;
                        x_d   = idx_next[1];
                        y_d   = idx_next[0];
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            DONE: begin
                state_d = IDLE;
                idx_d   = '0;
                cnt_d   = '0;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            x_q         <= 1'b0;
            y_q         <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_count_q <= '0;
            err_mask_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            x_q         <= x_d;
            y_q         <= y_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_count_q <= err_count_d;
            err_mask_q  <= err_mask_d;
        end
    end

    assign bus.x         = x_q;
    assign bus.y         = y_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.err_count = err_count_q;
    assign bus.err_mask  = err_mask_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// ----------------------------------------------------------------------------
// tb_truth_table_checker
// Three checker instances: index 0 with SETTLE=2 against a combinational
// NOR or a constant-1 gate, indices 1 and 2 with SETTLE=1 and SETTLE=3
// against a NOR gate with one cycle of registered delay.
// ----------------------------------------------------------------------------
module tb_truth_table_checker;

    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    truth_table_checker_if if_s2 ();
    truth_table_checker_if if_s1 ();
    truth_table_checker_if if_s3 ();

    logic       start_a [3];
    logic [3:0] func_a  [3];
    logic       abort0;
    logic       const_one;
    logic       nor_r1;
    logic       nor_r3;

    assign if_s2.start = start_a[0];
    assign if_s2.abort = abort0;
    assign if_s2.func  = func_a[0];
    assign if_s2.s     = const_one ? 1'b1 : ~(if_s2.x | if_s2.y);

    assign if_s1.start = start_a[1];
    assign if_s1.abort = 1'b0;
    assign if_s1.func  = func_a[1];
    assign if_s1.s     = nor_r1;

    assign if_s3.start = start_a[2];
    assign if_s3.abort = 1'b0;
    assign if_s3.func  = func_a[2];
    assign if_s3.s     = nor_r3;

    // Gate under test with one cycle of registered delay.
    always @(posedge clk) begin
        nor_r1 <= ~(if_s1.x | if_s1.y);
        nor_r3 <= ~(if_s3.x | if_s3.y);
    end

    truth_table_checker #(.SETTLE(2)) u_s2 (.clk(clk), .rst_n(rst_n), .bus(if_s2));
    truth_table_checker #(.SETTLE(1)) u_s1 (.clk(clk), .rst_n(rst_n), .bus(if_s1));
    truth_table_checker #(.SETTLE(3)) u_s3 (.clk(clk), .rst_n(rst_n), .bus(if_s3));

    logic       busy_w [3];
    logic       done_w [3];
    logic       pass_w [3];
    logic [1:0] xy_w   [3];
    logic [2:0] cnt_w  [3];
    logic [3:0] mask_w [3];

    assign busy_w[0] = if_s2.busy;      assign busy_w[1] = if_s1.busy;      assign busy_w[2] = if_s3.busy;
    assign done_w[0] = if_s2.done;      assign done_w[1] = if_s1.done;      assign done_w[2] = if_s3.done;
    assign pass_w[0] = if_s2.pass;      assign pass_w[1] = if_s1.pass;      assign pass_w[2] = if_s3.pass;
    assign xy_w[0]   = {if_s2.x, if_s2.y};
    assign xy_w[1]   = {if_s1.x, if_s1.y};
    assign xy_w[2]   = {if_s3.x, if_s3.y};
    assign cnt_w[0]  = if_s2.err_count; assign cnt_w[1]  = if_s1.err_count; assign cnt_w[2]  = if_s3.err_count;
    assign mask_w[0] = if_s2.err_mask;  assign mask_w[1] = if_s1.err_mask;  assign mask_w[2] = if_s3.err_mask;

    int n_checks;
    int n_fail;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle_zero(input string tag, input int sel);
        check_eq({tag, "_busy"}, 32'(busy_w[sel]), 0);
        check_eq({tag, "_done"}, 32'(done_w[sel]), 0);
        check_eq({tag, "_pass"}, 32'(pass_w[sel]), 0);
        check_eq({tag, "_xy"},   32'(xy_w[sel]),   0);
        check_eq({tag, "_cnt"},  32'(cnt_w[sel]),  0);
        check_eq({tag, "_mask"}, 32'(mask_w[sel]), 0);
    endtask

    // One full check on instance sel; optional start+abort together and
    // optional per-cycle trace of {x,y} against the expected vector index.
    task automatic run_check(input string tag, input int sel, input int settle,
                             input logic [3:0] f, input bit with_abort, input bit trace,
                             input logic exp_pass, input logic [2:0] exp_cnt,
                             input logic [3:0] exp_mask);
        int  n;
        bit  seen;
        @(negedge clk);
        func_a[sel]  = f;
        start_a[sel] = 1'b1;
        if (with_abort) abort0 = 1'b1;
        @(posedge clk);
        #1;
        start_a[sel] = 1'b0;
        abort0       = 1'b0;
        check_eq({tag, "_start_busy"}, 32'(busy_w[sel]), 1);
        check_eq({tag, "_start_clr"},  {pass_w[sel], cnt_w[sel], mask_w[sel]}, 0);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 64) begin
            if (trace) check_eq({tag, "_xy_trace"}, 32'(xy_w[sel]), 32'((n / settle) % 4));
            @(posedge clk);
            #1;
            n++;
            if (done_w[sel]) seen = 1'b1;
        end
        check_eq({tag, "_done_seen"}, 32'(seen), 1);
        check_eq({tag, "_latency"},   32'(n), 32'(4 * settle));
        check_eq({tag, "_pass"},      32'(pass_w[sel]), 32'(exp_pass));
        check_eq({tag, "_cnt"},       32'(cnt_w[sel]),  32'(exp_cnt));
        check_eq({tag, "_mask"},      32'(mask_w[sel]), 32'(exp_mask));
        check_eq({tag, "_done_busy_xy"}, {busy_w[sel], xy_w[sel]}, 0);
        @(posedge clk);
        #1;
        check_eq({tag, "_done_1cyc"}, 32'(done_w[sel]), 0);
        check_eq({tag, "_retain"},    {pass_w[sel], cnt_w[sel], mask_w[sel]},
                 {exp_pass, exp_cnt, exp_mask});
    endtask

    initial begin : stim
        bit seen_done;
        n_checks  = 0;
        n_fail    = 0;
        for (int i = 0; i < 3; i++) begin
            start_a[i] = 1'b0;
            func_a[i]  = 4'b0000;
        end
        abort0    = 1'b0;
        const_one = 1'b0;
        rst_n     = 1'b0;
        #23;
        check_idle_zero("reset", 0);
        check_idle_zero("reset_s1", 1);
        @(negedge clk);
        rst_n = 1'b1;

        // NOR with its own table, start accepted right after reset.
        run_check("nor_ok", 0, 2, 4'b0001, 1'b0, 1'b1, 1'b1, 3'd0, 4'b0000);

        // NOR checked against AND table, start+abort together in IDLE.
        run_check("nor_and", 0, 2, 4'b1000, 1'b1, 1'b0, 1'b0, 3'd2, 4'b1001);

        // Constant-1 gate against XOR, then against all-ones.
        const_one = 1'b1;
        run_check("one_xor", 0, 2, 4'b0110, 1'b0, 1'b0, 1'b0, 3'd2, 4'b1001);
        repeat (3) @(posedge clk);
        #1;
        check_eq("idle_hold", {pass_w[0], cnt_w[0], mask_w[0]}, {1'b0, 3'd2, 4'b1001});
        run_check("one_all1", 0, 2, 4'b1111, 1'b0, 1'b0, 1'b1, 3'd0, 4'b0000);

        // Abort during vector 2; vectors 0 and 1 mismatch, extra start ignored.
        @(negedge clk);
        func_a[0]  = 4'b1100;
        start_a[0] = 1'b1;
        @(posedge clk);
        #1;
        start_a[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        start_a[0] = 1'b1;
        @(posedge clk);
        #1;
        start_a[0] = 1'b0;
        check_eq("ign_start_xy",   32'(xy_w[0]),   32'd1);
        check_eq("ign_start_mask", 32'(mask_w[0]), 32'b0001);
        @(posedge clk);
        #1;
        check_eq("abort_pre_xy", 32'(xy_w[0]), 32'd2);
        abort0 = 1'b1;
        @(posedge clk);
        #1;
        abort0 = 1'b0;
        check_eq("abort_busy", 32'(busy_w[0]), 0);
        check_eq("abort_done", 32'(done_w[0]), 0);
        check_eq("abort_pass", 32'(pass_w[0]), 0);
        check_eq("abort_xy",   32'(xy_w[0]),   0);
        check_eq("abort_cnt",  32'(cnt_w[0]),  32'd2);
        check_eq("abort_mask", 32'(mask_w[0]), 32'b0011);
        seen_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done_w[0] || busy_w[0]) seen_done = 1'b1;
        end
        check_eq("abort_quiet", 32'(seen_done), 0);

        // Reset between clock edges in the middle of a check.
        const_one = 1'b0;
        @(negedge clk);
        func_a[0]  = 4'b1000;
        start_a[0] = 1'b1;
        @(posedge clk);
        #1;
        start_a[0] = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_eq("rst_pre_busy", 32'(busy_w[0]), 1);
        check_eq("rst_pre_mask", 32'(mask_w[0]), 32'b0001);
        rst_n = 1'b0;
        #1;
        check_idle_zero("rst_mid", 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_check("post_rst", 0, 2, 4'b0001, 1'b0, 1'b0, 1'b1, 3'd0, 4'b0000);

        // Registered-delay NOR: SETTLE=1 sees vector k-1's output, so only
        // vector 1 (previous NOR=1, expected 0) mismatches; SETTLE=3 passes.
        run_check("dly_s1", 1, 1, 4'b0001, 1'b0, 1'b0, 1'b0, 3'd1, 4'b0010);
        run_check("dly_s3", 2, 3, 4'b0001, 1'b0, 1'b1, 1'b1, 3'd0, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/truth_table_checker.md
TRUTH_TABLE_CHECKER -- requirements
Module: truth_table_checker

Interface
REQ-001 Parameter SETTLE, default 2, range 1..15: clock cycles each input vector is held before the DUT output is sampled.
REQ-002 clk  input  1  system clock, rising-edge active.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to run one full truth-table check; accepted only in IDLE.
REQ-005 abort  input  1  synchronous cancel of a running check.
REQ-006 func  input  4  expected truth table; func[k] is the expected DUT output for vector k, where k={x,y}.
REQ-007 s  input  1  output of the 2-input DUT gate under test.
REQ-008 x  output  1  first DUT input (MSB of vector index).
REQ-009 y  output  1  second DUT input (LSB of vector index).
REQ-010 busy  output  1  high while a check is in progress.
REQ-011 done  output  1  one-cycle pulse marking check completion.
REQ-012 pass  output  1  high when the last completed check had zero mismatches.
REQ-013 err_count  output  3  number of mismatching vectors in the current or last check (0..4).
REQ-014 err_mask  output  4  bit k set when vector k mismatched.

Function
REQ-015 The FSM shall have states IDLE, DRIVE and DONE.
REQ-016 In IDLE, x=0, y=0 and busy=0 shall hold, and pass, err_count and err_mask shall retain their values.
REQ-017 start=1 in IDLE at edge E0 shall move to DRIVE, set idx=0, clear err_count and err_mask, clear pass and set busy=1.
REQ-018 In DRIVE, {x,y} shall equal idx, registered and glitch-free, and shall change only at vector boundaries.
REQ-019 A settle counter shall count the cycles of each vector; s shall be sampled at edge E0+(k+1)*SETTLE for vector k.
REQ-020 On sampling, when s != func[idx], err_mask[idx] shall be set and err_count shall increment by 1.
REQ-021 After the sample of idx<3, idx shall increment and the settle counter shall restart.
REQ-022 After the sample of idx=3, the FSM shall enter DONE, i.e. in the cycle after edge E0+4*SETTLE.
REQ-023 The update from the idx=3 sample shall be included in the final results.
REQ-024 In DONE, done=1 for exactly one cycle, pass=(final err_count==0), busy=0 and x=y=0.
REQ-025 The FSM shall leave DONE for IDLE on the next edge.
REQ-026 start shall be ignored in DRIVE and DONE, with no queuing.
REQ-027 abort=1 in DRIVE shall return the FSM to IDLE on the next edge, with no done pulse and pass=0; err_count and err_mask shall keep their partial values.
REQ-028 abort in IDLE or DONE shall have no effect.
REQ-029 abort and start asserted together in IDLE: start shall win (abort has no effect in IDLE).
REQ-030 func shall be sampled at each sample edge, so it must be held stable by the user during busy.
REQ-031 err_count shall never exceed 4 and shall not wrap.
REQ-032 Total latency from the start edge to the done pulse shall be 4*SETTLE cycles.

Reset
REQ-033 rst_n=0 shall immediately force state IDLE, x=0, y=0, busy=0, done=0, pass=0, err_count=0, err_mask=0, idx=0 and settle counter=0, regardless of clk.
REQ-034 Reset asserted mid-check shall discard all partial results.
REQ-035 After rst_n deasserts, the block shall accept start on the first rising edge.

Verification
REQ-036 Bench SHALL cover: SETTLE=2, DUT=NOR, func=4'b0001, pulse start -> {x,y} steps 00,01,10,11, two cycles each; done pulses 8 cycles after start; pass=1, err_count=0, err_mask=0000.
REQ-037 Bench SHALL cover: DUT=NOR, func=4'b1000 (AND) -> pass=0, err_count=2, err_mask=1001.
REQ-038 Bench SHALL cover: s tied to 1, func=4'b0110 (XOR) -> err_count=2, err_mask=1001; next start with func=4'b1111 -> pass=1, results cleared at the start edge.
REQ-039 Bench SHALL cover: abort during vector 2 with mismatches at vectors 0 and 1 -> IDLE next edge, no done, pass=0, err_mask=0011, err_count=2; a second start while busy is ignored.
REQ-040 Bench SHALL cover: rst_n pulsed low mid-DRIVE between clock edges -> all outputs zero immediately; a fresh start completes normally.
REQ-041 Bench SHALL cover: SETTLE=1 with a DUT of 1-cycle registered delay -> documented mismatches; SETTLE=3 with the same DUT -> pass=1, done 12 cycles after start.
